// File: rtl/vector_write_back_controller_pkg.sv
// Shared encodings, FSM states and helpers for the vector write-back controller.
package vector_write_back_controller_pkg;

  // Request codes driven to the vector register file
  localparam logic [1:0] VECTOR_RF_NOP   = 2'd0;
  localparam logic [1:0] VECTOR_RF_WRITE = 2'd2;

  // Status codes returned by the vector register file
  localparam logic [1:0] RF_NOP      = 2'd0;
  localparam logic [1:0] RF_FINISHED = 2'd1;

  // Element width encodings
  localparam logic [2:0] ONE_BYTE   = 3'd0;
  localparam logic [2:0] TWO_BYTE   = 3'd1;
  localparam logic [2:0] FOUR_BYTE  = 3'd2;
  localparam logic [2:0] EIGHT_BYTE = 3'd3;

  typedef enum logic {ST_IDLE, ST_ISSUE} wb_state_e;

  function automatic logic dtype_legal(input logic [2:0] dt);
    return (dt == ONE_BYTE) || (dt == TWO_BYTE) || (dt == FOUR_BYTE) || (dt == EIGHT_BYTE);
  endfunction

  // Number of elements of width dt that fit in a vlen-bit register
  function automatic int unsigned lane_count(input logic [2:0] dt, input int unsigned vlen);
    case (dt)
      ONE_BYTE:   return vlen / 8;
      TWO_BYTE:   return vlen / 16;
      FOUR_BYTE:  return vlen / 32;
      EIGHT_BYTE: return vlen / 64;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/vector_write_back_controller_wb_fifo.sv
// Two-entry FIFO with 1-bit wrapping pointers and per-slot valid bits.
// Slots are exported so the owner can scan them for hazards.
module wb_fifo #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      din,
  output logic [W-1:0]      head,
  output logic [W-1:0]      head_nxt,
  output logic [1:0]        slot_vld,
  output logic [1:0][W-1:0] slot_mem,
  output logic              full,
  output logic              empty
);

  logic [1:0][W-1:0] mem;
  logic [1:0]        vld;
  logic              wr_ptr, rd_ptr;

  assign full     = &vld;
  assign empty    = ~|vld;
  assign head     = mem[rd_ptr];
  assign head_nxt = mem[~rd_ptr];
  assign slot_vld = vld;
  assign slot_mem = mem;

  // Push/pop bookkeeping; everything holds while en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (en) begin
      if (push && !full) begin
        mem[wr_ptr] <= din;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop && !empty) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= ~rd_ptr;
      end
    end
  end

endmodule

// File: rtl/vector_write_back_controller.sv
// Buffers vector results and writes them back to the VRF one at a time.
// An entry stays in the FIFO until the VRF reports it finished, so the FIFO
// head is always the entry currently being issued.
module vector_write_back_controller
  import vector_write_back_controller_pkg::*;
#(
  parameter int DATA_LEN    = 32,
  parameter int VECTOR_SIZE = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [4:0]                      in_rd,
  input  logic                            in_vm,
  input  logic [VECTOR_SIZE*DATA_LEN-1:0] in_mask,
  input  logic [VECTOR_SIZE*DATA_LEN-1:0] in_data,
  input  logic [DATA_LEN-1:0]             in_length,
  input  logic [2:0]                      in_data_type,
  output logic [1:0]                      rf_signal,
  output logic [4:0]                      rd,
  output logic                            vm,
  output logic [VECTOR_SIZE*DATA_LEN-1:0] mask,
  output logic [VECTOR_SIZE*DATA_LEN-1:0] data,
  output logic [DATA_LEN-1:0]             length,
  output logic [2:0]                      data_type,
  output logic                            write_back_enabled,
  input  logic [1:0]                      rf_status,
  output logic                            wb_done,
  output logic [4:0]                      wb_rd,
  output logic                            wb_err,
  input  logic [4:0]                      query_reg,
  output logic                            query_pending
);

  localparam int VLEN = VECTOR_SIZE * DATA_LEN;

  typedef struct packed {
    logic [4:0]          rd;
    logic                vm;
    logic [VLEN-1:0]     mask;
    logic [VLEN-1:0]     data;
    logic [DATA_LEN-1:0] length;
    logic [2:0]          data_type;
  } wb_entry_t;

  localparam int EW = $bits(wb_entry_t);

  wb_state_e          state, state_nxt;
  wb_entry_t          iss, load_entry, in_entry, head, head_nxt;
  wb_entry_t [1:0]    slots;
  logic [1:0][EW-1:0] slot_mem;
  logic [1:0]         slot_vld;
  logic               fifo_full, fifo_empty;
  logic               fire, legal, push, commit, load;
  logic [DATA_LEN-1:0] lanes;

  assign in_ready = rdy_in && !fifo_full && !rst;
  assign fire     = in_valid && in_ready;
  assign legal    = dtype_legal(in_data_type);
  assign push     = fire && legal;
  assign commit   = (state == ST_ISSUE) && (rf_status == RF_FINISHED) && rdy_in;

  // Clamp requested length to the register's element count
  assign lanes = DATA_LEN'(lane_count(in_data_type, VLEN));
  always_comb begin
    in_entry           = '0;
    in_entry.rd        = in_rd;
    in_entry.vm        = in_vm;
    in_entry.mask      = in_mask;
    in_entry.data      = in_data;
    in_entry.length    = (in_length > lanes) ? lanes : in_length;
    in_entry.data_type = in_data_type;
  end

  wb_fifo #(.W(EW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy_in),
    .push     (push),
    .pop      (commit),
    .din      (in_entry),
    .head     (head),
    .head_nxt (head_nxt),
    .slot_vld (slot_vld),
    .slot_mem (slot_mem),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign slots = slot_mem;

  // State register; frozen while rdy_in is low
  always_ff @(posedge clk) begin
    if (rst)         state <= ST_IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  // Next state, issue-register load selection and VRF-side controls.
  // On commit the next entry is either the second FIFO slot or, when the
  // FIFO held only the committing entry, the one being pushed right now.
  always_comb begin
    state_nxt          = state;
    load               = 1'b0;
    load_entry         = head;
    rf_signal          = VECTOR_RF_NOP;
    write_back_enabled = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_ISSUE;
          load      = 1'b1;
        end
      end
      ST_ISSUE: begin
        rf_signal          = VECTOR_RF_WRITE;
        write_back_enabled = (rf_status != RF_FINISHED);
        if (commit) begin
          if (fifo_full) begin
            load       = 1'b1;
            load_entry = head_nxt;
          end else if (push) begin
            load       = 1'b1;
            load_entry = in_entry;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Issue registers; they keep their contents in IDLE
  always_ff @(posedge clk) begin
    if (rst)                 iss <= '0;
    else if (rdy_in && load) iss <= load_entry;
  end

  assign rd        = iss.rd;
  assign vm        = iss.vm;
  assign mask      = iss.mask;
  assign data      = iss.data;
  assign length    = iss.length;
  assign data_type = iss.data_type;

  // Completion and error pulses, one cycle each
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_done <= 1'b0;
      wb_err  <= 1'b0;
      wb_rd   <= '0;
    end else begin
      wb_done <= commit;
      wb_err  <= fire && !legal;
      if (commit) wb_rd <= iss.rd;
    end
  end

  // Hazard lookup against queued and in-flight destinations
  always_comb begin
    query_pending = (state == ST_ISSUE) && (iss.rd == query_reg);
    for (int i = 0; i < 2; i++)
      if (slot_vld[i] && (slots[i].rd == query_reg)) query_pending = 1'b1;
  end

endmodule

// File: tb/tb_vector_write_back_controller.sv
// Directed bench for the write-back controller with a small VRF model.
module tb_vector_write_back_controller;
  import vector_write_back_controller_pkg::*;

  localparam int VLEN = 256;

  logic            clk = 1'b0;
  logic            rst, rdy_in, in_valid, in_ready, in_vm, vm;
  logic [4:0]      in_rd, rd, wb_rd, query_reg;
  logic [VLEN-1:0] in_mask, in_data, mask, data;
  logic [31:0]     in_length, length;
  logic [2:0]      in_data_type, data_type;
  logic [1:0]      rf_signal, rf_status;
  logic            write_back_enabled, wb_done, wb_err, query_pending;

  vector_write_back_controller #(.DATA_LEN(32), .VECTOR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_vm(in_vm), .in_mask(in_mask), .in_data(in_data),
    .in_length(in_length), .in_data_type(in_data_type), .rf_signal(rf_signal),
    .rd(rd), .vm(vm), .mask(mask), .data(data), .length(length), .data_type(data_type),
    .write_back_enabled(write_back_enabled), .rf_status(rf_status), .wb_done(wb_done),
    .wb_rd(wb_rd), .wb_err(wb_err), .query_reg(query_reg), .query_pending(query_pending)
  );

  always #5 clk = ~clk;

  // VRF model: one-cycle write, FINISHED held only while stalled
  logic [VLEN-1:0] vrf [32];
  int              wcnt = 0;
  always @(posedge clk) begin
    if (rst) rf_status <= RF_NOP;
    else if (rdy_in) begin
      if (rf_signal == VECTOR_RF_WRITE && write_back_enabled) begin
        vrf[rd]   <= data;
        rf_status <= RF_FINISHED;
        wcnt      <= wcnt + 1;
      end else rf_status <= RF_NOP;
    end
  end

  // Cycle counter and completion log
  int cyc = 0, ndone = 0, err_cnt = 0;
  int done_rd [16];
  int done_at [16];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wb_done && ndone < 16) begin
      done_rd[ndone] <= int'(wb_rd);
      done_at[ndone] <= cyc;
      ndone          <= ndone + 1;
    end
    if (wb_err) err_cnt <= err_cnt + 1;
  end

  int nvec = 0, nmis = 0;

  task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [2:0] dt, input logic [31:0] len,
                      input logic [VLEN-1:0] d);
    int n = 0;
    in_rd = r; in_data_type = dt; in_length = len; in_data = d; in_vm = 1'b1;
    in_mask = '1; in_valid = 1'b1;
    while (!in_ready && n < 20) begin tick; n++; end
    chk("push_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
  endtask

  logic [VLEN-1:0] d1;
  int base, w0, e0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rdy_in = 1'b1; in_valid = 1'b0; in_rd = '0; in_vm = 1'b0;
    in_mask = '0; in_data = '0; in_length = '0; in_data_type = '0; query_reg = '0;
    for (int i = 0; i < 8; i++) d1[i*32 +: 32] = i * 32'h11;

    // Reset state
    tick; tick;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wbe", write_back_enabled, 0);
    chk("rst_rf_signal", rf_signal, VECTOR_RF_NOP);
    chk("rst_wb_done", wb_done, 0);
    chk("rst_wb_err", wb_err, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_rd", rd, 0);
    rst = 1'b0;
    tick;

    // Single write
    push(5'd5, FOUR_BYTE, 8, d1);
    chk("s_wbe_lo", write_back_enabled, 0);
    tick;
    chk("s_wbe_hi", write_back_enabled, 1);
    chk("s_rf_signal", rf_signal, VECTOR_RF_WRITE);
    chk("s_rd", rd, 5);
    chk("s_length", length, 8);
    chk("s_vm", vm, 1);
    chk("s_data", data, d1);
    tick;
    chk("s_vrf", vrf[5], d1);
    chk("s_done_early", wb_done, 0);
    tick;
    chk("s_done", wb_done, 1);
    chk("s_wb_rd", wb_rd, 5);
    chk("s_idle", rf_signal, VECTOR_RF_NOP);
    tick;
    chk("s_done_pulse", wb_done, 0);

    // Back-to-back pushes rd=1,2,3
    base = ndone;
    in_vm = 1'b1; in_mask = '1; in_data_type = FOUR_BYTE; in_length = 8;
    in_valid = 1'b1; in_rd = 5'd1; in_data = 1;
    chk("b_rdy1", in_ready, 1);
    tick;
    in_rd = 5'd2; in_data = 2;
    chk("b_rdy2", in_ready, 1);
    tick;
    in_rd = 5'd3; in_data = 3;
    chk("b_full", in_ready, 0);
    for (int n = 0; n < 20 && !in_ready; n++) tick;
    tick;
    in_valid = 1'b0;
    repeat (10) tick;
    chk("b_ncommit", ndone - base, 3);
    chk("b_order0", done_rd[base], 1);
    chk("b_order1", done_rd[base+1], 2);
    chk("b_order2", done_rd[base+2], 3);
    chk("b_gap01", done_at[base+1] - done_at[base], 2);
    chk("b_gap12", done_at[base+2] - done_at[base+1], 2);
    chk("b_vrf3", vrf[3], 3);

    // Length clamp
    push(5'd10, ONE_BYTE, 40, d1);
    tick;
    chk("c_one_byte", length, 32);
    chk("c_dtype", data_type, ONE_BYTE);
    repeat (4) tick;
    push(5'd11, EIGHT_BYTE, 9, d1);
    tick;
    chk("c_eight_byte", length, 4);
    repeat (4) tick;
    push(5'd12, TWO_BYTE, 5, d1);
    tick;
    chk("c_no_clamp", length, 5);
    repeat (4) tick;

    // Illegal data type
    w0 = wcnt; e0 = err_cnt;
    push(5'd9, 3'b111, 8, d1);
    chk("i_err", wb_err, 1);
    query_reg = 5'd9; #1;
    chk("i_not_queued", query_pending, 0);
    tick;
    chk("i_err_pulse", wb_err, 0);
    chk("i_idle", rf_signal, VECTOR_RF_NOP);
    repeat (3) tick;
    chk("i_no_write", wcnt, w0);
    chk("i_err_once", err_cnt, e0 + 1);

    // Hazard while the VRF is stalled
    query_reg = 5'd7;
    push(5'd7, FOUR_BYTE, 8, d1);
    #1 chk("h_pend_q", query_pending, 1);
    tick;
    rdy_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      query_reg = 5'd7; #1;
      chk("h_pend7", query_pending, 1);
      chk("h_wbe", write_back_enabled, 1);
      chk("h_in_ready", in_ready, 0);
      query_reg = 5'd8; #1;
      chk("h_pend8", query_pending, 0);
      tick;
    end
    rdy_in = 1'b1; query_reg = 5'd7;
    tick;
    chk("h_pend_write", query_pending, 1);
    chk("h_done_early", wb_done, 0);
    tick;
    chk("h_done", wb_done, 1);
    chk("h_wb_rd", wb_rd, 7);
    chk("h_pend_clear", query_pending, 0);

    // FINISHED seen during a stall is picked up afterwards
    tick;
    push(5'd6, FOUR_BYTE, 8, d1);
    tick; tick;
    rdy_in = 1'b0;
    repeat (3) tick;
    chk("f_no_done", wb_done, 0);
    chk("f_wbe", write_back_enabled, 0);
    rdy_in = 1'b1;
    tick;
    chk("f_done", wb_done, 1);
    chk("f_wb_rd", wb_rd, 6);
    tick;

    // Reset while issuing
    push(5'd4, FOUR_BYTE, 8, d1);
    tick;
    chk("r_wbe", write_back_enabled, 1);
    base = ndone;
    rst = 1'b1; #1;
    chk("r_in_ready", in_ready, 0);
    tick;
    rst = 1'b0;
    chk("r_idle", rf_signal, VECTOR_RF_NOP);
    chk("r_wbe_lo", write_back_enabled, 0);
    chk("r_rd", rd, 0);
    query_reg = 5'd4; #1;
    chk("r_fifo_empty", query_pending, 0);
    repeat (4) tick;
    chk("r_no_done", ndone - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/vector_write_back_controller.md
VECTOR_WRITE_BACK_CONTROLLER -- requirements
Module: vector_write_back_controller

Interface
REQ-001 Parameter DATA_LEN, default 32, memory data unit width in bits.
REQ-002 Parameter VECTOR_SIZE, default 8; vector register width is VECTOR_SIZE*DATA_LEN bits (VLEN).
REQ-003 Port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1, reset; synchronous, active-high.
REQ-005 Port rdy_in, input, 1, global ready; when low, all state is frozen.
REQ-006 Ports in_valid (input, 1) and in_ready (output, 1) form the upstream result handshake.
REQ-007 Upstream payload inputs: in_rd [4:0], in_vm [1], in_mask [VLEN], in_data [VLEN], in_length [DATA_LEN], in_data_type [2:0].
REQ-008 VRF-side outputs: rf_signal [1:0], rd [4:0], vm [1], mask [VLEN], data [VLEN], length [DATA_LEN], data_type [2:0], write_back_enabled [1].
REQ-009 Port rf_status, input, 2, status returned by the vector register file.
REQ-010 Completion outputs: wb_done (1, one-cycle pulse) and wb_rd [4:0], the register just committed.
REQ-011 Error output: wb_err, 1, one-cycle pulse when an entry with an illegal data_type is dropped.
REQ-012 Hazard query: query_reg [4:0] input; query_pending [1] output.

Function
REQ-013 Transfer occurs on a cycle with in_valid && in_ready && rdy_in; the payload is pushed into a 2-entry FIFO.
REQ-014 in_ready = rdy_in && FIFO not full; there is no same-cycle bypass when full.
REQ-015 On push, length is clamped to the lane count of in_data_type: ONE_BYTE=VLEN/8, TWO_BYTE=VLEN/16, FOUR_BYTE=VLEN/32, EIGHT_BYTE=VLEN/64 (32/16/8/4 at defaults).
REQ-016 On push with an illegal in_data_type, the entry is not stored, and wb_err pulses on the next cycle.
REQ-017 The FSM has states IDLE and ISSUE.
REQ-018 IDLE->ISSUE: when the FIFO is non-empty; the head entry is latched into the issue registers.
REQ-019 In ISSUE: rf_signal=VECTOR_RF_WRITE, and rd/vm/mask/data/length/data_type are driven from the issue registers.
REQ-020 In ISSUE: write_back_enabled = (rf_status != RF_FINISHED), combinational.
REQ-021 In ISSUE with rf_status==RF_FINISHED and rdy_in high:
  - pop the FIFO;
  - next cycle: wb_done=1 and wb_rd=committed rd;
  - next state: ISSUE with the new head if the FIFO is non-empty, else IDLE.
REQ-022 In IDLE: rf_signal=VECTOR_RF_NOP, write_back_enabled=0, and the data/mask outputs hold their last values.
REQ-023 Steady-state throughput is one commit per 2 cycles.
REQ-024 The FIFO may push and pop in the same cycle when not full; occupancy is then unchanged.
REQ-025 FIFO pointers are 1 bit and wrap modulo 2; occupancy is 0..2.
REQ-026 query_pending (combinational) = 1 if query_reg equals the rd of any valid FIFO entry or of the in-flight ISSUE entry.
REQ-027 While rdy_in is low:
  - no push, pop, or state change;
  - write_back_enabled stays as computed;
  - a missed FINISHED is re-observed later, because the VRF status persists.

Reset
REQ-028 On rst: state=IDLE, FIFO empty, in_ready=0 during the reset cycle, write_back_enabled=0, rf_signal=VECTOR_RF_NOP, wb_done=0, wb_err=0, wb_rd=0, and the issue registers are cleared to 0.
REQ-029 Reset mid-ISSUE abandons the entry without a wb_done pulse; a partial commit already written to the VRF is not undone.

Structure
REQ-030 VECTOR_RF_WRITE, VECTOR_RF_NOP, RF_FINISHED, RF_NOP, and the ONE/TWO/FOUR/EIGHT_BYTE encodings come from the shared defines file; there are no local literals.
REQ-031 The 2-entry FIFO is one sub-module, wb_fifo, parameterised on payload width.

Verification
REQ-032 Single write: push rd=5, FOUR_BYTE, length=8, vm=1, data=i*0x11.
  - write_back_enabled rises 1 cycle after push;
  - VRF v5 equals the data;
  - wb_done with wb_rd=5 pulses 2 cycles after issue.
REQ-033 Back-to-back: three pushes rd=1,2,3 on consecutive cycles.
  - in_ready drops after 2 accepted;
  - commits occur in order 1,2,3 at 2-cycle spacing.
REQ-034 Clamp: ONE_BYTE with length=40 -> length output is 32; EIGHT_BYTE with length=9 -> length output is 4.
REQ-035 Illegal data_type=3'b111 -> no VRF write, wb_err pulses once, FIFO stays empty.
REQ-036 Hazard: push rd=7 and stall the VRF with rdy_in=0 for 5 cycles.
  - query_reg=7 -> query_pending=1 until the wb_done cycle;
  - query_reg=8 -> query_pending=0 throughout.
REQ-037 Reset asserted mid-ISSUE -> next cycle state is IDLE, FIFO empty, no wb_done pulse.
